// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the capture-FIFO write arbiter.
//   arb_state_e    : arbiter FSM state (idle/arbitrating vs. burst to one channel)
//   DATA_W_DEFAULT : default word width, matches the capture FIFO
//   next_rr()      : round-robin pick over up to RR_MAX_CH requesters
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    localparam int DATA_W_DEFAULT = 64;
    localparam int RR_MAX_CH      = 8;

    // Returns the first set bit of valid[n-1:0] searching from last+1
    // upward with wrap-around. With no request set, returns last; the
    // caller qualifies the result with |valid.
    function automatic logic [2:0] next_rr(input logic [RR_MAX_CH-1:0] valid,
                                           input logic [2:0]           last,
                                           input int                   n);
        logic [2:0] pick;
        int         idx;
        pick = last;
        // Walk from the farthest candidate to the nearest so the nearest
        // requester after 'last' is the one left in 'pick'.
        for (int k = RR_MAX_CH; k >= 1; k--) begin
            if (k <= n) begin
                idx = (int'(last) + k) % n;
                if (valid[idx[2:0]]) pick = idx[2:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Channel-side and FIFO-side handshake bundle for fifo_write_arbiter.
//   ch_valid/ch_data/ch_ready : per-channel valid/ready word stream
//                               (channel i data is ch_data[i])
//   fifo_full/fifo_wr_en/fifo_din : FIFO write port
// Modports: slave = arbiter side, master = channels + FIFO side.
interface fifo_write_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 64
);
    logic [NUM_CH-1:0]             ch_valid;
    logic [NUM_CH-1:0][DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]             ch_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_W-1:0]             fifo_din;

    modport slave (
        input  ch_valid, ch_data, fifo_full,
        output ch_ready, fifo_wr_en, fifo_din
    );

    modport master (
        output ch_valid, ch_data, fifo_full,
        input  ch_ready, fifo_wr_en, fifo_din
    );
endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
//   req_i   : request vector (N = 2..8)
//   last_i  : index granted last time; search starts at last_i+1
//   idx_o   : chosen requester (meaningful only when found_o=1)
//   found_o : at least one request present
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);
    logic [RR_MAX_CH-1:0] req_ext;
    logic [2:0]           pick;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req_i;
    end

    assign pick    = next_rr(req_ext, 3'(last_i), N);
    assign idx_o   = pick[IW-1:0];
    assign found_o = |req_i;
endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares the capture FIFO write port among NUM_CH channels.
// Round-robin grant with burst lock; one registered output stage.
//   clk, rst   : clock, async active-low reset
//   bus        : channel valid/ready streams and FIFO write port (slave)
//   grant_id   : channel currently granted (valid while busy=1)
//   busy       : arbiter is in a burst
//   word_count : words written to the FIFO, wraps at 2^32
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    fifo_write_arbiter_if.slave       bus,
    output logic [$clog2(NUM_CH)-1:0] grant_id,
    output logic                      busy,
    output logic [31:0]               word_count
);
    localparam int IW = $clog2(NUM_CH);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [IW-1:0]     last_q,  last_d;
    logic [7:0]        bcnt_q,  bcnt_d;
    logic              out_vld_q;
    logic [DATA_W-1:0] out_data_q;
    logic [31:0]       word_cnt_q;

    logic [IW-1:0]     pick_idx;
    logic              pick_found;
    logic              accept_ok;
    logic              gnt_valid;
    logic              ch_xfer;
    logic              fifo_xfer;
    logic [7:0]        bcnt_inc;
    logic [NUM_CH-1:0] ready_vec;

    rr_pick #(.N(NUM_CH)) u_pick (
        .req_i   (bus.ch_valid),
        .last_i  (last_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // The output register can take a word when it is empty or is being
    // drained this cycle; this makes ch_ready combinational on fifo_full.
    assign accept_ok = !out_vld_q || !bus.fifo_full;
    assign gnt_valid = bus.ch_valid[grant_q];
    assign ch_xfer   = (state_q == ARB_BURST) && accept_ok && gnt_valid;
    assign fifo_xfer = out_vld_q && !bus.fifo_full;
    assign bcnt_inc  = bcnt_q + 8'd1;

    always_comb begin
        ready_vec = '0;
        if (state_q == ARB_BURST && accept_ok) ready_vec[grant_q] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    bcnt_d  = '0;
                    state_d = ARB_BURST;
                end
            end
            ARB_BURST: begin
                // Only an accept opportunity can end a burst, so a full
                // FIFO holds the grant for as long as it stays full.
                if (accept_ok) begin
                    if (gnt_valid) begin
                        bcnt_d = bcnt_inc;
                        if (bcnt_inc == 8'(MAX_BURST)) begin
                            state_d = ARB_IDLE;
                            last_d  = grant_q;
                        end
                    end else begin
                        state_d = ARB_IDLE;
                        last_d  = grant_q;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_CH - 1);
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Load wins over drain so a word can enter while the previous one
    // leaves. Data is left untouched on a plain drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else if (ch_xfer) begin
            out_vld_q  <= 1'b1;
            out_data_q <= bus.ch_data[grant_q];
        end else if (fifo_xfer) begin
            out_vld_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           word_cnt_q <= '0;
        else if (fifo_xfer) word_cnt_q <= word_cnt_q + 32'd1;
    end

    assign bus.ch_ready   = ready_vec;
    assign bus.fifo_wr_en = out_vld_q;
    assign bus.fifo_din   = out_data_q;
    assign grant_id       = grant_q;
    assign busy           = (state_q == ARB_BURST);
    assign word_count     = word_cnt_q;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: two instances (MAX_BURST 16 and 2) with
// counter-driven channel models and a scoreboard of expected FIFO words.
module tb_fifo_write_arbiter;
    localparam int NUM_CH = 4;
    localparam int DW     = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DW)) bus_a ();
    fifo_write_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DW)) bus_b ();

    logic [1:0]  gid_a, gid_b;
    logic        busy_a, busy_b;
    logic [31:0] wc_a, wc_b;

    fifo_write_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DW), .MAX_BURST(16)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave),
        .grant_id(gid_a), .busy(busy_a), .word_count(wc_a)
    );
    fifo_write_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DW), .MAX_BURST(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave),
        .grant_id(gid_b), .busy(busy_b), .word_count(wc_b)
    );

    // Channel model: rem words left, nxt = word currently presented.
    int          rem  [2][NUM_CH];
    logic [63:0] nxt  [2][NUM_CH];
    int          nacc [2][NUM_CH];
    logic [63:0] exp_a[$], exp_b[$];
    logic        pend_a, pend_b;
    logic [63:0] pdat_a, pdat_b;
    int          n_chk = 0, n_fail = 0, cyc = 0;
    int          t_a0_16, t_a3_1, tb_first, tb_last;
    logic [63:0] hold_din;
    logic        hold_en;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_CH; i++) begin
            bus_a.ch_valid[i] = (rem[0][i] > 0);
            bus_a.ch_data[i]  = nxt[0][i];
            bus_b.ch_valid[i] = (rem[1][i] > 0);
            bus_b.ch_data[i]  = nxt[1][i];
        end
    endtask

    // One clock: sample at negedge, advance channel models after posedge.
    task automatic step();
        logic [NUM_CH-1:0] acc_a, acc_b;
        logic [63:0]       e;
        @(negedge clk);
        acc_a = bus_a.ch_valid & bus_a.ch_ready;
        acc_b = bus_b.ch_valid & bus_b.ch_ready;
        chk("rdy_onehot_a", 64'($onehot0(bus_a.ch_ready)), 1);
        chk("rdy_onehot_b", 64'($onehot0(bus_b.ch_ready)), 1);
        if (pend_a) begin
            chk("lat_en_a", 64'(bus_a.fifo_wr_en), 1);
            chk("lat_din_a", bus_a.fifo_din, pdat_a);
        end
        if (pend_b) begin
            chk("lat_en_b", 64'(bus_b.fifo_wr_en), 1);
            chk("lat_din_b", bus_b.fifo_din, pdat_b);
        end
        pend_a = 1'b0;
        pend_b = 1'b0;
        if (bus_a.fifo_wr_en && !bus_a.fifo_full) begin
            chk("sb_avail_a", 64'(exp_a.size() > 0), 1);
            if (exp_a.size() > 0) begin
                e = exp_a.pop_front();
                chk("sb_data_a", bus_a.fifo_din, e);
            end
        end
        if (bus_b.fifo_wr_en && !bus_b.fifo_full) begin
            chk("sb_avail_b", 64'(exp_b.size() > 0), 1);
            if (exp_b.size() > 0) begin
                e = exp_b.pop_front();
                chk("sb_data_b", bus_b.fifo_din, e);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (acc_a[i]) begin pend_a = 1'b1; pdat_a = bus_a.ch_data[i]; end
            if (acc_b[i]) begin pend_b = 1'b1; pdat_b = bus_b.ch_data[i]; end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NUM_CH; i++) begin
            if (acc_a[i]) begin
                rem[0][i]--; nxt[0][i]++; nacc[0][i]++;
                if (i == 0 && nacc[0][i] == 16) t_a0_16 = cyc;
                if (i == 3 && nacc[0][i] == 1)  t_a3_1  = cyc;
            end
            if (acc_b[i]) begin
                rem[1][i]--; nxt[1][i]++; nacc[1][i]++;
                if (tb_first < 0) tb_first = cyc;
                tb_last = cyc;
            end
        end
        drive();
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NUM_CH; i++) begin
                rem[d][i] = 0; nxt[d][i] = '0; nacc[d][i] = 0;
            end
        exp_a.delete(); exp_b.delete();
        pend_a = 1'b0; pend_b = 1'b0;
        t_a0_16 = -1; t_a3_1 = -1; tb_first = -1; tb_last = -1;
    endtask

    // Called at posedge+1; leaves us at posedge+1 with reset released.
    task automatic do_reset();
        rst = 1'b0;
        clear_model();
        bus_a.fifo_full = 1'b0;
        bus_b.fifo_full = 1'b0;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_model();
        bus_a.fifo_full = 1'b0;
        bus_b.fifo_full = 1'b0;
        drive();
        #1 rst = 1'b0;
        #2;
        chk("rst_wr_en", 64'(bus_a.fifo_wr_en), 0);
        chk("rst_din", bus_a.fifo_din, 0);
        chk("rst_ready", 64'(bus_a.ch_ready), 0);
        chk("rst_gid", 64'(gid_a), 0);
        chk("rst_busy", 64'(busy_a), 0);
        chk("rst_wc", 64'(wc_a), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Single channel: ch2, five words
        rem[0][2] = 5; nxt[0][2] = 64'hA0;
        for (int k = 0; k < 5; k++) exp_a.push_back(64'hA0 + 64'(k));
        drive();
        #2;
        chk("t1_bubble_rdy", 64'(bus_a.ch_ready), 0);
        step();
        chk("t1_busy", 64'(busy_a), 1);
        chk("t1_gnt", 64'(gid_a), 2);
        repeat (9) step();
        chk("t1_wc", 64'(wc_a), 5);
        chk("t1_exit", 64'(busy_a), 0);
        chk("t1_sb_empty", 64'(exp_a.size()), 0);

        // Round-robin on the MAX_BURST=2 instance
        for (int i = 0; i < NUM_CH; i++) begin
            rem[1][i] = 4;
            nxt[1][i] = 64'h2000 + 64'(i * 16);
        end
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_CH; i++)
                for (int k = 0; k < 2; k++)
                    exp_b.push_back(64'h2000 + 64'(i * 16 + r * 2 + k));
        drive();
        for (int k = 0; k < 60 && exp_b.size() > 0; k++) step();
        step();
        chk("t2_drain", 64'(exp_b.size()), 0);
        chk("t2_span", 64'(tb_last - tb_first), 22);
        chk("t2_wc", 64'(wc_b), 16);

        // Backpressure: ch1 streaming, full for 7 cycles
        rem[0][1] = 10; nxt[0][1] = 64'hB00;
        for (int k = 0; k < 10; k++) exp_a.push_back(64'hB00 + 64'(k));
        drive();
        for (int k = 0; k < 20 && nacc[0][1] < 3; k++) step();
        chk("t3_started", 64'(nacc[0][1]), 3);
        bus_a.fifo_full = 1'b1;
        hold_en  = bus_a.fifo_wr_en;
        hold_din = bus_a.fifo_din;
        #1;
        chk("t3_rdy_full", 64'(bus_a.ch_ready), 0);
        chk("t3_hold_en0", 64'(hold_en), 1);
        for (int k = 0; k < 7; k++) begin
            step();
            chk("t3_hold_en", 64'(bus_a.fifo_wr_en), 64'(hold_en));
            chk("t3_hold_din", bus_a.fifo_din, hold_din);
            chk("t3_rdy", 64'(bus_a.ch_ready), 0);
            chk("t3_gid", 64'(gid_a), 1);
        end
        bus_a.fifo_full = 1'b0;
        for (int k = 0; k < 40 && exp_a.size() > 0; k++) step();
        step();
        chk("t3_drain", 64'(exp_a.size()), 0);
        chk("t3_wc", 64'(wc_a), 15);

        // Burst limit: ch0 and ch3 both streaming, MAX_BURST=16
        do_reset();
        rem[0][0] = 20; nxt[0][0] = 64'hD00;
        rem[0][3] = 20; nxt[0][3] = 64'hE00;
        for (int k = 0; k < 16; k++) exp_a.push_back(64'hD00 + 64'(k));
        for (int k = 0; k < 16; k++) exp_a.push_back(64'hE00 + 64'(k));
        for (int k = 16; k < 20; k++) exp_a.push_back(64'hD00 + 64'(k));
        for (int k = 16; k < 20; k++) exp_a.push_back(64'hE00 + 64'(k));
        drive();
        for (int k = 0; k < 120 && exp_a.size() > 0; k++) step();
        step();
        chk("t4_drain", 64'(exp_a.size()), 0);
        chk("t4_gap", 64'(t_a3_1 - t_a0_16), 2);
        chk("t4_wc", 64'(wc_a), 40);

        // Counter wrap
        do_reset();
        force dut_a.word_cnt_q = 32'hFFFF_FFFE;
        step();
        release dut_a.word_cnt_q;
        chk("t5_preset", 64'(wc_a), 64'h0000_0000_FFFF_FFFE);
        rem[0][2] = 3; nxt[0][2] = 64'hF00;
        for (int k = 0; k < 3; k++) exp_a.push_back(64'hF00 + 64'(k));
        drive();
        for (int k = 0; k < 20 && exp_a.size() > 0; k++) step();
        step();
        chk("t5_drain", 64'(exp_a.size()), 0);
        chk("t5_wrap", 64'(wc_a), 1);

        // Async reset mid-burst with a word in the output register
        rem[0][1] = 50; nxt[0][1] = 64'h500;
        for (int k = 0; k < 50; k++) exp_a.push_back(64'h500 + 64'(k));
        drive();
        for (int k = 0; k < 20 && nacc[0][1] < 3; k++) step();
        chk("t6_pre_vld", 64'(bus_a.fifo_wr_en), 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_wr_en", 64'(bus_a.fifo_wr_en), 0);
        chk("t6_ready", 64'(bus_a.ch_ready), 0);
        chk("t6_busy", 64'(busy_a), 0);
        clear_model();
        for (int i = 0; i < NUM_CH; i++) begin
            rem[0][i] = 2;
            nxt[0][i] = 64'h1000 * 64'(i + 1);
            for (int k = 0; k < 2; k++) exp_a.push_back(64'h1000 * 64'(i + 1) + 64'(k));
        end
        drive();
        @(posedge clk);
        #1 rst = 1'b1;
        step();
        chk("t6_busy_after", 64'(busy_a), 1);
        chk("t6_first_gnt", 64'(gid_a), 0);
        for (int k = 0; k < 40 && exp_a.size() > 0; k++) step();
        step();
        chk("t6_drain", 64'(exp_a.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the write side of the 64-bit capture FIFO among NUM_CH sniffer channels.
- Arbitration is round-robin with burst lock; each channel uses a valid/ready handshake.
- Drives the FIFO's wr_en/din from a single registered output stage and honours the FIFO's full flag as backpressure.
- Sits between the per-channel capture front-ends and the FIFO wrapper.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- DATA_W, 64, word width; must match the FIFO data width.
- MAX_BURST, 16, maximum words accepted per grant before re-arbitration (1..255).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ch_valid  in  NUM_CH  per-channel word valid.
- ch_data  in  NUM_CH*DATA_W  per-channel word; channel i occupies bits [i*DATA_W +: DATA_W].
- ch_ready  out  NUM_CH  per-channel accept; one-hot or zero.
- fifo_full  in  1  FIFO full flag (not ready).
- fifo_wr_en  out  1  FIFO write strobe (valid).
- fifo_din  out  DATA_W  FIFO write data.
- grant_id  out  $clog2(NUM_CH)  index of the channel currently granted; valid while busy=1.
- busy  out  1  FSM is in BURST.
- word_count  out  32  total words written to the FIFO; wraps modulo 2^32.

Behaviour:
- Reset (rst=0, async) values:
  - ch_ready=0, fifo_wr_en=0, fifo_din=0, grant_id=0, busy=0, word_count=0.
  - FSM=IDLE, burst counter=0, last-grant pointer=NUM_CH-1, so channel 0 has top priority after reset.
- Transfer definitions:
  - Channel transfer: ch_valid[i] & ch_ready[i] at a rising edge.
  - FIFO transfer: fifo_wr_en & !fifo_full at a rising edge.
- Output stage: one register (out_vld, out_data); fifo_wr_en=out_vld, fifo_din=out_data.
  - Load on a channel transfer.
  - Clear on a FIFO transfer with no simultaneous load.
  - Load and drain in the same cycle is allowed, giving full throughput of one word per cycle.
- Latency: a word accepted from a channel at edge k is driven on fifo_wr_en/fifo_din during the cycle after edge k.
- FIFO hold rule: while fifo_full=1, fifo_wr_en and fifo_din are held stable.
- ch_ready[i] = busy & (grant_id==i) & (!out_vld | !fifo_full). This term is combinational from fifo_full.
- IDLE state:
  - Scan ch_valid round-robin starting at last+1 (mod NUM_CH).
  - On the first asserted channel j: grant_id<=j, burst counter<=0, go to BURST.
  - If no channel is valid, stay in IDLE.
  - Arbitration costs one bubble cycle per grant; no word is accepted in IDLE.
- BURST state:
  - Each channel transfer increments the burst counter.
  - Exit to IDLE (busy<=0, last<=grant_id) on either condition:
    - a) a channel transfer that brings the counter to MAX_BURST;
    - b) ch_ready[grant_id]=1 while ch_valid[grant_id]=0, i.e. the channel idled at an accept opportunity.
  - Backpressure (ch_ready=0) never ends a burst; a full FIFO extends the grant indefinitely.
- Fairness: under continuous requests from all channels, grants rotate 0,1,..,NUM_CH-1,0,...
- word_count increments by 1 on each FIFO transfer and wraps 0xFFFFFFFF -> 0.
- Data is never dropped or duplicated. Channels must hold ch_data stable while ch_valid=1 and not accepted.
- Reset mid-burst:
  - Any pending output word is discarded; fifo_wr_en is low immediately (async).
  - Arbitration restarts from channel 0.

Decomposition:
- Package fifo_arb_pkg holds:
  - the FSM state typedef (enum logic {ARB_IDLE, ARB_BURST});
  - DATA_W_DEFAULT=64;
  - the round-robin helper function next_rr(valid, last) returning the granted index.
- One natural sub-module: rr_pick, a combinational round-robin priority picker (req vector + last pointer -> index + found). It is reusable by other arbiters in the design.
- Output register, burst counter and word counter stay in the top module.

Test Plan:
- Single channel: ch_valid[2]=1 with 5 words 0xA0..0xA4, fifo_full=0.
  - After 1 idle arbitration cycle, the words appear consecutively on fifo_din, each one cycle after its accept.
  - word_count=5; burst exits when valid drops.
- Round-robin: all 4 channels continuously valid, MAX_BURST=2.
  - FIFO order is ch0,ch0,ch1,ch1,ch2,ch2,ch3,ch3,ch0,...
  - Exactly one bubble cycle between bursts.
- Backpressure: ch1 streaming, fifo_full=1 for 7 cycles mid-burst.
  - fifo_wr_en/fifo_din hold stable and ch_ready=0.
  - After full drops, the stream resumes with no loss or duplicate; grant_id remains 1 throughout.
- Burst limit: MAX_BURST=16 with ch0 and ch3 continuously valid.
  - Exactly 16 ch0 words, then a grant to ch3.
  - busy drops for one cycle between the bursts.
- Wrap: force word_count to 0xFFFFFFFE, write 3 words -> word_count=0x00000001.
- Async reset mid-burst with out_vld=1: assert rst=0 between edges.
  - fifo_wr_en=0, ch_ready=0 and busy=0 immediately.
  - After release with all channels valid, the first grant_id=0.
